pendulum_loop_sequencer: RTL and testbench

Sequences one inverted-pendulum control cycle per sample period: requests an angle sample from the ADC front end over a req/ack handshake, computes the signed error against the target angle, and converts it into a motor direction and PWM duty. Counts consecutive out-of-band samples and latches a fault that kills the motor until software clears it. Sits between the angle-sensor ADC interface and the cart motor driver.

---
 rtl/pend_pkg.sv | 30 +++
 rtl/pend_pwm.sv | 59 +++++
 rtl/pendulum_loop_sequencer.sv | 165 ++++++++++++++++
 tb/tb_pendulum_loop_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pend_pkg.sv
// pend_pkg: shared types and constants for the pendulum loop sequencer.
//   pend_state_t : sequencer FSM states
//   duty_t       : 8-bit PWM duty
//   FC_*         : fault_cause codes
//   sat_duty     : |error| -> duty, doubled and saturated at 255
package pend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_COMP  = 3'd2,
    ST_UPD   = 3'd3,
    ST_FAULT = 3'd4
  } pend_state_t;

  typedef logic [7:0] duty_t;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_BAND    = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  localparam logic [7:0] TARGET_ANGLE_DEFAULT = 8'h80;

  // mag is at most 128, so anything above 127 doubles past 255.
  function automatic duty_t sat_duty(input logic [8:0] mag);
    if (mag > 9'd127) return 8'hFF;
    else              return {mag[6:0], 1'b0};
  endfunction

endpackage

// File: rtl/pend_pwm.sv
// pend_pwm: free-running 8-bit PWM with pending/active duty and direction.
//   clk, reset     : clock, asynchronous active-low reset
//   load           : write load_duty/load_dir into the pending registers
//   kill           : fault - duty, pending duty and pwm forced to 0
//   off            : loop disabled - pwm and pending duty forced to 0
//   pwm, duty, dir : motor drive, applied duty, applied direction
// Pending values reach the outputs only on the 255->0 counter wrap so a
// PWM period is never cut short or stretched mid-cycle.
module pend_pwm
  import pend_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  duty_t load_duty,
  input  logic  load_dir,
  input  logic  kill,
  input  logic  off,
  output logic  pwm,
  output duty_t duty,
  output logic  dir
);

  logic [7:0] pwm_cnt;
  duty_t      pend_duty;
  duty_t      act_duty;
  logic       pend_dir;
  logic       act_dir;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt   <= '0;
      pend_duty <= '0;
      act_duty  <= '0;
      pend_dir  <= 1'b0;
      act_dir   <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;

      if (kill || off)  pend_duty <= '0;
      else if (load)    pend_duty <= load_duty;
      if (load)         pend_dir  <= load_dir;

      if (pwm_cnt == 8'hFF) begin
        act_duty <= kill ? '0 : pend_duty;
        act_dir  <= pend_dir;
      end else if (kill) begin
        act_duty <= '0;
      end
    end
  end

  // Kill gates the outputs combinationally so the motor stops in the
  // first FAULT cycle rather than one register stage later.
  assign duty = kill ? '0 : act_duty;
  assign dir  = act_dir;
  assign pwm  = !kill && !off && (pwm_cnt < act_duty);

endmodule

// File: rtl/pendulum_loop_sequencer.sv
// pendulum_loop_sequencer: one inverted-pendulum control cycle per period.
//   clk, reset          : clock, asynchronous active-low reset
//   enable              : loop run enable
//   adc_req/adc_ack     : req/ack handshake; adc_data captured when ack=1
//                         while adc_req=1; adc_req drops the next cycle
//   fault_clr           : pulse that leaves FAULT
//   motor_pwm/motor_dir : motor driver outputs; duty = applied duty
//   busy, fault         : REQ/COMP/UPD, FAULT
//   fault_cause         : 01 out-of-band, 10 ack timeout, 00 none
//   state               : current FSM state for observation
// Build option: PEND_ACK_TIMEOUT_EN adds an ack timeout in REQ.
module pendulum_loop_sequencer
  import pend_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV   = 1000,
  parameter logic [7:0]  TARGET_ANGLE = TARGET_ANGLE_DEFAULT,
  parameter logic [7:0]  FAULT_BAND   = 8'h40,
  parameter int unsigned FAULT_LIMIT  = 4,
  parameter int unsigned ACK_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        adc_req,
  input  logic        adc_ack,
  input  logic [7:0]  adc_data,
  input  logic        fault_clr,
  output logic        motor_pwm,
  output logic        motor_dir,
  output duty_t       duty,
  output logic        busy,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output pend_state_t state
);

  if (SAMPLE_DIV < 8 || FAULT_LIMIT < 1 || FAULT_LIMIT > 15 || ACK_TIMEOUT < 1) begin : g_bad_cfg
    $error("pendulum_loop_sequencer: parameter out of range");
  end

  localparam int unsigned CW = $clog2(SAMPLE_DIV);

  // Period counter: free-runs while enabled, parked at 0 otherwise.
  logic [CW-1:0] period_cnt;
  logic          tick;

  assign tick = enable && (period_cnt == CW'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                period_cnt <= '0;
    else if (!enable || tick)  period_cnt <= '0;
    else                       period_cnt <= period_cnt + 1'b1;
  end

  // Error path, evaluated in COMP from the captured sample.
  logic [7:0]        sample;
  logic              dir_q;
  duty_t             duty_q;
  logic [3:0]        fault_cnt;
  logic signed [8:0] err;
  logic [8:0]        mag;
  logic              oob;
  logic [3:0]        cnt_next;
  logic              new_dir;

  assign err      = $signed({1'b0, sample}) - $signed({1'b0, TARGET_ANGLE});
  assign mag      = err[8] ? (~err + 9'd1) : err;
  assign oob      = mag > {1'b0, FAULT_BAND};
  assign cnt_next = oob ? fault_cnt + 4'd1 : 4'd0;
  // Zero error keeps the previous direction.
  assign new_dir  = (err == 9'sd0) ? dir_q : !err[8];

`ifdef PEND_ACK_TIMEOUT_EN
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      adc_req     <= 1'b0;
      busy        <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= FC_NONE;
      sample      <= '0;
      dir_q       <= 1'b0;
      duty_q      <= '0;
      fault_cnt   <= '0;
`ifdef PEND_ACK_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick) begin
            state   <= ST_REQ;
            adc_req <= 1'b1;
            busy    <= 1'b1;
`ifdef PEND_ACK_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end
        ST_REQ: begin
          if (adc_ack) begin
            sample  <= adc_data;
            adc_req <= 1'b0;
            state   <= ST_COMP;
          end
`ifdef PEND_ACK_TIMEOUT_EN
          else if (tmo_cnt == TW'(ACK_TIMEOUT - 1)) begin
            adc_req     <= 1'b0;
            busy        <= 1'b0;
            fault       <= 1'b1;
            fault_cause <= FC_TIMEOUT;
            state       <= ST_FAULT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        ST_COMP: begin
          fault_cnt <= cnt_next;
          dir_q     <= new_dir;
          duty_q    <= sat_duty(mag);
          if (cnt_next >= 4'(FAULT_LIMIT)) begin
            busy        <= 1'b0;
            fault       <= 1'b1;
            fault_cause <= FC_BAND;
            state       <= ST_FAULT;
          end else begin
            state <= ST_UPD;
          end
        end
        ST_UPD: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        ST_FAULT: begin
          if (fault_clr) begin
            fault       <= 1'b0;
            fault_cause <= FC_NONE;
            fault_cnt   <= '0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  pend_pwm u_pwm (
    .clk       (clk),
    .reset     (reset),
    .load      (state == ST_UPD),
    .load_duty (duty_q),
    .load_dir  (dir_q),
    .kill      (state == ST_FAULT),
    .off       (!enable),
    .pwm       (motor_pwm),
    .duty      (duty),
    .dir       (motor_dir)
  );

endmodule

// File: tb/tb_pendulum_loop_sequencer.sv
// Bench for pendulum_loop_sequencer (SAMPLE_DIV=16, FAULT_LIMIT=4).
// Expected {dir, duty} pairs are queued when a sample is acked and
// compared once a PWM wrap has passed.
module tb_pendulum_loop_sequencer;
  import pend_pkg::*;

  localparam logic [7:0] TGT = 8'h80;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        adc_req;
  logic        adc_ack;
  logic [7:0]  adc_data;
  logic        fault_clr;
  logic        motor_pwm;
  logic        motor_dir;
  duty_t       duty;
  logic        busy;
  logic        fault;
  logic [1:0]  fault_cause;
  pend_state_t state;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];   // {dir, duty}
  logic       model_dir;
  logic       feed_on;
  logic [7:0] feed_data;

  pendulum_loop_sequencer #(
    .SAMPLE_DIV(16), .TARGET_ANGLE(TGT), .FAULT_BAND(8'h40),
    .FAULT_LIMIT(4), .ACK_TIMEOUT(255)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .adc_req(adc_req),
    .adc_ack(adc_ack), .adc_data(adc_data), .fault_clr(fault_clr),
    .motor_pwm(motor_pwm), .motor_dir(motor_dir), .duty(duty),
    .busy(busy), .fault(fault), .fault_cause(fault_cause), .state(state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic logic [8:0] model_out(input logic [7:0] d, input logic hold);
    int   e;
    int   m;
    int   du;
    logic dr;
    e  = int'(d) - int'(TGT);
    m  = (e < 0) ? -e : e;
    du = (m * 2 > 255) ? 255 : m * 2;
    dr = (e > 0) ? 1'b1 : ((e < 0) ? 1'b0 : hold);
    return {dr, du[7:0]};
  endfunction

  // ---------------- driver tasks ----------------
  // One clock; inputs settle 1 time unit after the edge. In feed mode
  // every request is acked with feed_data.
  task automatic step();
    @(posedge clk);
    #1;
    adc_ack = feed_on && adc_req;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (adc_req) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_req: adc_req=%b after 80 cycles, required 1", adc_req);
    end
  endtask

  // Waits for a request, holds ack off for 'delay' cycles, acks with d.
  // Returns with the DUT in the cycle after capture.
  task automatic manual_sample(input logic [7:0] d, input int delay, output logic [8:0] exp_v);
    bit ok;
    feed_on = 1'b0;
    adc_ack = 1'b0;
    exp_v   = model_out(d, model_dir);
    wait_req(ok);
    if (!ok) return;
    repeat (delay) step();
    adc_data  = d;
    adc_ack   = 1'b1;
    model_dir = exp_v[8];
    step();
  endtask

  task automatic feed(input logic [7:0] d);
    feed_data = d;
    adc_data  = d;
    feed_on   = 1'b1;
    adc_ack   = adc_req;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_scoreboard(input string name);
    logic [8:0] e;
    repeat (300) step();
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, no expected value", name);
      return;
    end
    e = exp_q.pop_front();
    if (duty !== e[7:0]) begin
      errors++;
      $display("FAIL %s duty: got %h, required %h", name, duty, e[7:0]);
    end
    checks++;
    if (motor_dir !== e[8]) begin
      errors++;
      $display("FAIL %s dir: got %b, required %b", name, motor_dir, e[8]);
    end
  endtask

  task automatic count_pwm(input string name, input int required);
    int n = 0;
    repeat (256) begin
      step();
      if (motor_pwm) n++;
    end
    checks++;
    if (n !== required) begin
      errors++;
      $display("FAIL %s pwm_high: got %0d of 256, required %0d", name, n, required);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; adc_ack = 1'b0; adc_data = 8'h00;
    fault_clr = 1'b0; feed_on = 1'b0; feed_data = 8'h00; model_dir = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 7;
    if (adc_req !== 1'b0)      begin errors++; $display("FAIL reset adc_req: got %b, required 0", adc_req); end
    if (motor_pwm !== 1'b0)    begin errors++; $display("FAIL reset motor_pwm: got %b, required 0", motor_pwm); end
    if (motor_dir !== 1'b0)    begin errors++; $display("FAIL reset motor_dir: got %b, required 0", motor_dir); end
    if (duty !== 8'h00)        begin errors++; $display("FAIL reset duty: got %h, required 00", duty); end
    if (busy !== 1'b0)         begin errors++; $display("FAIL reset busy: got %b, required 0", busy); end
    if (fault !== 1'b0)        begin errors++; $display("FAIL reset fault: got %b, required 0", fault); end
    if (fault_cause !== 2'b00) begin errors++; $display("FAIL reset fault_cause: got %b, required 00", fault_cause); end
    reset  = 1'b1;
    enable = 1'b1;
  endtask

  task automatic test_positive();
    logic [8:0] e;
    manual_sample(8'h90, 2, e);
    exp_q.push_back(e);
    checks++;
    if (state !== ST_COMP) begin
      errors++;
      $display("FAIL positive state_after_ack: got %0d, required %0d", state, ST_COMP);
    end
    feed(8'h90);
    check_scoreboard("positive");
    count_pwm("positive", int'(e[7:0]));
  endtask

  task automatic test_dir_hold();
    logic [8:0] e;
    manual_sample(8'h80, 0, e);
    exp_q.push_back(e);
    feed(8'h80);
    check_scoreboard("dir_hold");
    count_pwm("dir_hold", int'(e[7:0]));
  endtask

  task automatic test_negative();
    logic [8:0] e;
    manual_sample(8'h70, 1, e);
    exp_q.push_back(e);
    feed(8'h70);
    check_scoreboard("negative");
  endtask

  // Full-scale negative error saturates the duty; feed stays off so
  // the fault counter only sees one out-of-band sample.
  task automatic test_saturation();
    logic [8:0] e;
    manual_sample(8'h00, 0, e);
    exp_q.push_back(e);
    feed_on = 1'b0;
    adc_ack = 1'b0;
    check_scoreboard("saturation");
    manual_sample(8'h7F, 0, e);
    feed(8'h7F);
    repeat (40) step();
  endtask

  task automatic band_sample(input logic [7:0] d);
    logic [8:0] e;
    manual_sample(d, 0, e);
    repeat (2) step();
  endtask

  task automatic test_fault();
    logic [8:0] e;
    int n;
    for (int i = 0; i < 3; i++) begin
      band_sample(8'hD0);
      checks++;
      if (fault !== 1'b0) begin errors++; $display("FAIL fault_early sample %0d: fault=%b, required 0", i + 1, fault); end
    end
    manual_sample(8'hD0, 0, e);
    step();
    checks += 5;
    if (fault !== 1'b1)          begin errors++; $display("FAIL fault_trip fault: got %b, required 1", fault); end
    if (fault_cause !== FC_BAND) begin errors++; $display("FAIL fault_trip cause: got %b, required 01", fault_cause); end
    if (motor_pwm !== 1'b0)      begin errors++; $display("FAIL fault_trip motor_pwm: got %b, required 0", motor_pwm); end
    if (duty !== 8'h00)          begin errors++; $display("FAIL fault_trip duty: got %h, required 00", duty); end
    if (busy !== 1'b0)           begin errors++; $display("FAIL fault_trip busy: got %b, required 0", busy); end
    // Ticks keep arriving but FAULT must not request samples.
    n = 0;
    repeat (40) begin step(); if (adc_req) n++; end
    checks++;
    if (n !== 0) begin errors++; $display("FAIL fault_no_req: adc_req high %0d cycles, required 0", n); end
    fault_clr = 1'b1; step(); fault_clr = 1'b0;
    checks += 3;
    if (fault !== 1'b0)          begin errors++; $display("FAIL fault_clr fault: got %b, required 0", fault); end
    if (fault_cause !== FC_NONE) begin errors++; $display("FAIL fault_clr cause: got %b, required 00", fault_cause); end
    if (state !== ST_IDLE)       begin errors++; $display("FAIL fault_clr state: got %0d, required %0d", state, ST_IDLE); end
  endtask

  // After a clear the counter restarts; a sample exactly at the band
  // edge is in-band and resets the run.
  task automatic test_band_pattern();
    logic [8:0] e;
    for (int i = 0; i < 3; i++) band_sample(8'hD0);
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL band_after_clr: fault=%b, required 0", fault); end
    band_sample(8'hC0);
    for (int i = 0; i < 3; i++) band_sample(8'hD0);
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL band_reset_by_edge: fault=%b, required 0", fault); end
    manual_sample(8'hD0, 0, e);
    step();
    checks += 2;
    if (fault !== 1'b1)          begin errors++; $display("FAIL band_trip fault: got %b, required 1", fault); end
    if (fault_cause !== FC_BAND) begin errors++; $display("FAIL band_trip cause: got %b, required 01", fault_cause); end
    fault_clr = 1'b1; step(); fault_clr = 1'b0;
    manual_sample(8'h90, 0, e);
    exp_q.push_back(e);
    feed(8'h90);
    check_scoreboard("resume");
  endtask

  task automatic test_ack_timeout();
    bit ok;
    int n;
    int guard;
    // Park in IDLE with feed on, then withhold acks from a fresh request.
    guard = 0;
    while ((adc_req || busy) && guard < 100) begin step(); guard++; end
    feed_on = 1'b0;
    adc_ack = 1'b0;
    wait_req(ok);
    n = 0;
`ifdef PEND_ACK_TIMEOUT_EN
    while (!fault && n < 400) begin step(); n++; end
    checks += 3;
    if (n !== 255)                  begin errors++; $display("FAIL timeout cycles: got %0d, required 255", n); end
    if (fault_cause !== FC_TIMEOUT) begin errors++; $display("FAIL timeout cause: got %b, required 10", fault_cause); end
    if (adc_req !== 1'b0)           begin errors++; $display("FAIL timeout adc_req: got %b, required 0", adc_req); end
    fault_clr = 1'b1; step(); fault_clr = 1'b0;
`else
    repeat (300) begin step(); if (!adc_req) n++; end
    checks += 2;
    if (n !== 0)        begin errors++; $display("FAIL no_timeout adc_req: low %0d cycles, required 0", n); end
    if (fault !== 1'b0) begin errors++; $display("FAIL no_timeout fault: got %b, required 0", fault); end
`endif
    feed(8'h90);
    repeat (40) step();
  endtask

  task automatic test_enable();
    int nreq = 0;
    int npwm = 0;
    enable = 1'b0;
    exp_q.push_back({model_dir, 8'h00});
    repeat (20) step();
    feed_on = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (i % 50 == 10) begin
        adc_data = 8'hD0;
        adc_ack  = 1'b1;   // stray ack with no request
      end
      step();
      if (adc_req)   nreq++;
      if (motor_pwm) npwm++;
    end
    checks += 3;
    if (nreq !== 0)     begin errors++; $display("FAIL enable_off adc_req: high %0d cycles, required 0", nreq); end
    if (npwm !== 0)     begin errors++; $display("FAIL enable_off motor_pwm: high %0d cycles, required 0", npwm); end
    if (fault !== 1'b0) begin errors++; $display("FAIL enable_off fault: got %b, required 0", fault); end
    check_scoreboard("enable_off");
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_req();
    bit ok;
    feed_on = 1'b0;
    adc_ack = 1'b0;
    wait_req(ok);
    #2 reset = 1'b0;
    #1;
    checks += 5;
    if (adc_req !== 1'b0)      begin errors++; $display("FAIL mid_reset adc_req: got %b, required 0", adc_req); end
    if (busy !== 1'b0)         begin errors++; $display("FAIL mid_reset busy: got %b, required 0", busy); end
    if (motor_dir !== 1'b0)    begin errors++; $display("FAIL mid_reset motor_dir: got %b, required 0", motor_dir); end
    if (duty !== 8'h00)        begin errors++; $display("FAIL mid_reset duty: got %h, required 00", duty); end
    if (state !== ST_IDLE)     begin errors++; $display("FAIL mid_reset state: got %0d, required %0d", state, ST_IDLE); end
    step();
    reset = 1'b1;
    model_dir = 1'b0;
    exp_q.delete();
    wait_req(ok);
    checks++;
    if (fault_cause !== FC_NONE) begin errors++; $display("FAIL mid_reset recover cause: got %b, required 00", fault_cause); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_positive();
    test_dir_hold();
    test_negative();
`ifndef PEND_ACK_TIMEOUT_EN
    test_saturation();
`endif
    test_fault();
    test_band_pattern();
    test_ack_timeout();
    test_enable();
    test_reset_mid_req();
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
